sdram_req_prefetch: RTL

Single-clock read-side adapter between the controller-domain end of the host request FIFO and the SDRAM command scheduler. It pops request words from the FIFO's registered read port and holds them in a 2-entry prefetch buffer. Each word is split into write-enable, address and write-data fields and presented on a valid/ready interface. It sustains one request per cycle while hiding the FIFO's one-cycle read latency.

---
 rtl/sdram_req_prefetch.sv | 106 ++++++++++
 1 files changed

// File: rtl/sdram_req_prefetch.sv
// sdram_req_prefetch: 2-entry prefetch buffer between the registered read port
// of the host request FIFO and the SDRAM command scheduler. It pops ahead so the
// FIFO's one-cycle read latency is hidden, and it can still deliver one request
// per cycle. Each FIFO word is split into we / addr / wdata, and those fields
// are always decoded from the head register.
module sdram_req_prefetch #(
  parameter  int AddrWidth = 24,
  parameter  int DataWidth = 16,
  localparam int ReqWidth  = 1 + AddrWidth + DataWidth
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  // FIFO read side
  output logic                 o_fifo_rd_en,
  input  logic [ReqWidth-1:0]  i_fifo_rd_data,
  input  logic                 i_fifo_empty,
  // control
  input  logic                 i_flush,
  // scheduler side
  output logic                 o_req_valid,
  input  logic                 i_req_ready,
  output logic                 o_req_we,
  output logic [AddrWidth-1:0] o_req_addr,
  output logic [DataWidth-1:0] o_req_wdata,
  output logic [1:0]           o_level
);

  // FIFO word layout: we in the MSB, then addr, then wdata in the LSBs.
  typedef struct packed {
    logic                 we;
    logic [AddrWidth-1:0] addr;
    logic [DataWidth-1:0] wdata;
  } req_t;

  req_t       head_q, head_d;
  req_t       tail_q, tail_d;
  req_t       rd_word;
  logic [1:0] occ_q, occ_d;     // buffered entries, 0..2
  logic       inf_q, inf_d;     // a pop was issued last cycle
  logic       drop_q, drop_d;   // word arriving this cycle belongs to a flushed pop

  logic       pop_out;          // head handed to the scheduler this cycle
  logic       cap;              // in-flight word is written into the buffer
  logic [1:0] occ_post;         // occupancy after this cycle's pop_out
  logic [2:0] pend;             // committed slots: occupancy + in flight - leaving

  assign rd_word  = req_t'(i_fifo_rd_data);
  assign pop_out  = o_req_valid && i_req_ready;
  assign occ_post = occ_q - 2'(pop_out);
  assign pend     = 3'(occ_q) + 3'(inf_q) - 3'(pop_out);
  assign cap      = inf_q && !drop_q && !i_flush;

  // Pop only when a slot is guaranteed to be free when the word lands.
  // This makes overflow impossible. The pop is also held off during reset.
  assign o_fifo_rd_en = i_rst_n && !i_fifo_empty && !i_flush && (pend < 3'd2);

  // Next-state logic: shift the tail forward on a pop, then capture the
  // in-flight word into the first free slot. Flush empties the buffer.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    inf_d  = o_fifo_rd_en;
    drop_d = i_flush && o_fifo_rd_en;
    if (i_flush) begin
      occ_d = 2'd0;
    end else begin
      if (pop_out && (occ_q == 2'd2)) begin
        head_d = tail_q;
      end
      if (cap) begin
        if (occ_post == 2'd0) begin
          head_d = rd_word;
        end else begin
          tail_d = rd_word;
        end
      end
      occ_d = occ_post + 2'(cap);
    end
  end

  // Buffer state registers. Entries are cleared on reset so that the outputs
  // come up at zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= 2'd0;
      inf_q  <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
      inf_q  <= inf_d;
      drop_q <= drop_d;
    end
  end

  assign o_req_valid = (occ_q != 2'd0);
  assign o_level     = occ_q;
  assign o_req_we    = head_q.we;
  assign o_req_addr  = head_q.addr;
  assign o_req_wdata = head_q.wdata;

endmodule
